// File: rtl/ecc_memory_scrubber.sv
// Background scrubber for a SECDED memory: walks every address, rewrites words the
// decoder corrected, and always yields the memory port to the host.
module ecc_memory_scrubber #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int INTERVAL   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scrub_en,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wr_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_sec,
  input  logic                  mem_ded,
  output logic                  busy,
  output logic                  pass_done,
  output logic                  ded_event,
  output logic [7:0]            corrected_count,
  output logic [7:0]            uncorrectable_count,
  output logic [ADDR_WIDTH-1:0] last_err_addr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0]         INTERVAL_LAST = CW'(INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR     = ADDR_WIDTH'(DEPTH - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] scrub_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [CW-1:0]         interval_cnt;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  wb_cancel;
  logic                  hazard;

  assign next_addr  = (scrub_addr == LAST_ADDR) ? '0 : scrub_addr + 1'b1;
  assign hazard     = host_req && host_we && (host_addr == scrub_addr) && (state == WRITE);
  assign host_rdata = mem_rdata;
  assign busy       = (state != IDLE);

  // The host owns the port whenever it asks; a write is never issued during reset.
  always_comb begin
    mem_addr  = scrub_addr;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    if (host_req) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wr_en = host_we;
    end else if (state == WRITE) begin
      mem_wdata = wb_data;
      mem_wr_en = !wb_cancel;
    end
    if (rst) begin
      mem_wr_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      scrub_addr          <= '0;
      interval_cnt        <= '0;
      wb_data             <= '0;
      wb_cancel           <= 1'b0;
      pass_done           <= 1'b0;
      ded_event           <= 1'b0;
      corrected_count     <= 8'd0;
      uncorrectable_count <= 8'd0;
      last_err_addr       <= '0;
    end else begin
      pass_done <= 1'b0;
      ded_event <= 1'b0;
      if (host_req) begin
        // Frozen this cycle; a host write over the pending word makes the writeback stale.
        if (hazard) begin
          wb_cancel <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (!scrub_en) begin
              interval_cnt <= '0;
            end else if (interval_cnt == INTERVAL_LAST) begin
              interval_cnt <= '0;
              state        <= READ;
            end else begin
              interval_cnt <= interval_cnt + CW'(1);
            end
          end
          READ: begin
            if (mem_ded) begin
              if (uncorrectable_count != 8'hFF) begin
                uncorrectable_count <= uncorrectable_count + 8'd1;
              end
              ded_event     <= 1'b1;
              last_err_addr <= scrub_addr;
              scrub_addr    <= next_addr;
              pass_done     <= (scrub_addr == LAST_ADDR);
              state         <= IDLE;
            end else if (mem_sec) begin
              wb_data <= mem_rdata;
              if (corrected_count != 8'hFF) begin
                corrected_count <= corrected_count + 8'd1;
              end
              last_err_addr <= scrub_addr;
              state         <= WRITE;
            end else begin
              scrub_addr <= next_addr;
              pass_done  <= (scrub_addr == LAST_ADDR);
              state      <= IDLE;
            end
          end
          WRITE: begin
            wb_cancel  <= 1'b0;
            scrub_addr <= next_addr;
            pass_done  <= (scrub_addr == LAST_ADDR);
            state      <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ecc_memory_scrubber.sv
// Scoreboard bench for ecc_memory_scrubber: a pass-level reference model predicts
// scrub writes, ded events and pass_done with their cycle; a monitor checks them.
module tb_ecc_memory_scrubber;

  localparam int DW       = 8;
  localparam int AW       = 4;
  localparam int DEPTH    = 16;
  localparam int INTERVAL = 4;

  localparam int K_WR   = 0;
  localparam int K_DED  = 1;
  localparam int K_PASS = 2;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          scrub_en;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr_en;
  logic [DW-1:0] mem_rdata;
  logic          mem_sec;
  logic          mem_ded;
  logic          busy;
  logic          pass_done;
  logic          ded_event;
  logic [7:0]    corrected_count;
  logic [7:0]    uncorrectable_count;
  logic [AW-1:0] last_err_addr;

  logic [DW-1:0] mem     [DEPTH];
  logic          sec_f   [DEPTH];
  logic          ded_f   [DEPTH];
  logic [DW-1:0] nxt_mem [DEPTH];
  logic          nxt_sec [DEPTH];
  logic          nxt_ded [DEPTH];
  logic          load_req;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  int   exp_corr = 0;
  int   exp_unc = 0;
  int   exp_last = 0;

  ecc_memory_scrubber #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .INTERVAL(INTERVAL)
  ) dut (
    .clk(clk), .rst(rst), .scrub_en(scrub_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata), .mem_sec(mem_sec), .mem_ded(mem_ded),
    .busy(busy), .pass_done(pass_done), .ded_event(ded_event),
    .corrected_count(corrected_count), .uncorrectable_count(uncorrectable_count),
    .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory with a corrected-read port; any write stores clean data and clears the error flags.
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]   <= nxt_mem[i];
        sec_f[i] <= nxt_sec[i];
        ded_f[i] <= nxt_ded[i];
      end
    end else if (mem_wr_en) begin
      mem[mem_addr]   <= mem_wdata;
      sec_f[mem_addr] <= 1'b0;
      ded_f[mem_addr] <= 1'b0;
    end
  end

  assign mem_rdata = mem[mem_addr];
  assign mem_sec   = sec_f[mem_addr];
  assign mem_ded   = ded_f[mem_addr];

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic observe(input int kind, input int addr, input int data);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_event_kind", kind, -1);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", kind, e.kind);
      if (e.kind != K_PASS) checkOutput("event_addr", addr, e.addr);
      if (e.kind == K_WR) checkOutput("event_wdata", data, e.data);
      if (e.cyc >= 0) checkOutput("event_cycle", cyc, e.cyc);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_wr_en && !host_req) observe(K_WR, int'(mem_addr), int'(mem_wdata));
        if (ded_event) observe(K_DED, int'(last_err_addr), 0);
        if (pass_done) observe(K_PASS, 0, 0);
      end
    end
  end

  // One pass over the loaded image, step by step; t < 0 leaves cycle positions unchecked.
  task automatic model_pass(input int t0, input int hz);
    int t;
    int rd;
    int adv;
    t = t0;
    for (int a = 0; a < DEPTH; a++) begin
      rd = t + INTERVAL;
      if (nxt_ded[a]) begin
        if (exp_unc < 255) exp_unc++;
        exp_last = a;
        exp_q.push_back('{K_DED, a, 0, (t0 < 0) ? -1 : rd + 1});
        adv = rd;
      end else if (nxt_sec[a]) begin
        if (exp_corr < 255) exp_corr++;
        exp_last = a;
        if (a != hz) exp_q.push_back('{K_WR, a, int'(nxt_mem[a]), (t0 < 0) ? -1 : rd + 1});
        adv = rd + 1;
      end else begin
        adv = rd;
      end
      t = adv + 1;
    end
    exp_q.push_back('{K_PASS, 0, 0, (t0 < 0) ? -1 : t});
  endtask

  task automatic fill(input int sec_pct, input int ded_pct);
    for (int i = 0; i < DEPTH; i++) begin
      nxt_mem[i] = DW'($urandom);
      nxt_sec[i] = ($urandom_range(0, 99) < sec_pct);
      nxt_ded[i] = ($urandom_range(0, 99) < ded_pct);
    end
  endtask

  // Loads the prepared image, releases reset, starts scrubbing and (optionally) predicts the pass.
  task automatic applyStimulus(input int timed, input int hz, input int modeled);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    rst      = 1'b0;
    scrub_en = 1'b1;
    if (modeled != 0) model_pass(timed != 0 ? cyc : -1, hz);
  endtask

  task automatic finish_pass();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("pass_pending_events", exp_q.size(), 0);
    exp_q.delete();
    scrub_en = 1'b0;
    checkOutput("corrected_count", int'(corrected_count), exp_corr);
    checkOutput("uncorrectable_count", int'(uncorrectable_count), exp_unc);
    checkOutput("last_err_addr", int'(last_err_addr), exp_last);
  endtask

  task automatic wait_read(input int addr);
    int found = 0;
    for (int i = 0; i < 400 && found == 0; i++) begin
      @(negedge clk);
      if (busy && !host_req && !mem_wr_en && int'(mem_addr) == addr) found = 1;
    end
    checkOutput("read_reached", found, 1);
  endtask

  task automatic check_reset();
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_pass_done", int'(pass_done), 0);
    checkOutput("rst_ded_event", int'(ded_event), 0);
    checkOutput("rst_corrected", int'(corrected_count), 0);
    checkOutput("rst_uncorrectable", int'(uncorrectable_count), 0);
    checkOutput("rst_last_err_addr", int'(last_err_addr), 0);
    checkOutput("rst_mem_wr_en", int'(mem_wr_en), 0);
    checkOutput("rst_mem_addr", int'(mem_addr), 0);
    checkOutput("rst_mem_wdata", int'(mem_wdata), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    scrub_en   = 1'b0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    load_req   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset();

    $display("[TB] clean pass straight out of reset");
    fill(0, 0);
    applyStimulus(1, -1, 1);
    finish_pass();

    $display("[TB] sec at 5 and ded+sec at 9");
    fill(0, 0);
    nxt_mem[5] = 8'h5A; nxt_sec[5] = 1'b1;
    nxt_sec[9] = 1'b1;  nxt_ded[9] = 1'b1;
    applyStimulus(1, -1, 1);
    finish_pass();

    $display("[TB] random error images");
    for (int p = 0; p < 4; p++) begin
      fill(25, 12);
      applyStimulus(1, -1, 1);
      finish_pass();
    end

    $display("[TB] host read freezes READ of address 3");
    fill(0, 0);
    nxt_mem[3] = 8'hFF;
    applyStimulus(0, -1, 1);
    wait_read(2);
    repeat (INTERVAL + 1) @(posedge clk);
    #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd3;
    #1;
    checkOutput("host_rdata", int'(host_rdata), 8'hFF);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput("frozen_busy", int'(busy), 1);
    end
    host_req = 1'b0;
    #1;
    checkOutput("reread_busy", int'(busy), 1);
    checkOutput("reread_addr", int'(mem_addr), 3);
    checkOutput("reread_wr_en", int'(mem_wr_en), 0);
    @(posedge clk);
    #1;
    checkOutput("after_read_busy", int'(busy), 0);
    checkOutput("after_read_addr", int'(mem_addr), 4);
    finish_pass();

    $display("[TB] host write cancels writeback at address 5");
    fill(0, 0);
    nxt_mem[5] = 8'h5A; nxt_sec[5] = 1'b1;
    applyStimulus(0, 5, 1);
    wait_read(5);
    @(posedge clk);
    #1;
    checkOutput("wb_addr", int'(mem_addr), 5);
    checkOutput("wb_wdata", int'(mem_wdata), 8'h5A);
    checkOutput("wb_wr_en", int'(mem_wr_en), 1);
    host_req = 1'b1; host_we = 1'b1; host_addr = 4'd5; host_wdata = 8'h11;
    @(posedge clk);
    #1;
    host_req = 1'b0; host_we = 1'b0;
    #1;
    checkOutput("cancelled_busy", int'(busy), 1);
    checkOutput("cancelled_wr_en", int'(mem_wr_en), 0);
    finish_pass();
    checkOutput("host_word_kept", int'(mem[5]), 8'h11);

    $display("[TB] consecutive sec reads saturate the corrected count");
    for (int p = 0; p < 19; p++) begin
      fill(100, 0);
      applyStimulus(1, -1, 1);
      finish_pass();
    end

    $display("[TB] reset during WRITE");
    fill(0, 0);
    nxt_sec[0] = 1'b1;
    applyStimulus(0, -1, 0);
    wait_read(0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("wr_en_during_reset", int'(mem_wr_en), 0);
    @(posedge clk);
    #1;
    check_reset();
    checkOutput("no_write_in_reset", int'(sec_f[0]), 1);
    scrub_en = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
